inertial_integrator: RTL

Produces the fused pitch estimate that feeds the balance PID. It consumes raw gyro pitch-rate and Z-accel samples from the inertial SPI front end. The block self-calibrates sensor offsets after reset, then runs a gyro integrator with a complementary accel-fusion correction. It emits `ptch`, `ptch_rt` and a `vld` strobe toward the controller.

---
 rtl/inertial_integrator.sv | 133 +++++++++++++
 1 files changed

// File: rtl/inertial_integrator.sv
// Gyro/accel pitch integrator: offset self-calibration after reset or clr, then gyro integration with accel-fusion nudge.
// Outputs register 1 cycle after vld_in; no backpressure, every strobe (including back-to-back) is consumed.
module inertial_integrator #(
    parameter int FAST_SIM    = 1,
    parameter int FUSION_GAIN = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        vld_in,
    input  logic [15:0] ptch_rt_raw,
    input  logic [15:0] AZ,
    output logic [15:0] ptch,
    output logic [15:0] ptch_rt,
    output logic        vld,
    output logic        cal_done
);

    localparam int CAL_SHIFT = (FAST_SIM != 0) ? 4 : 10;
    localparam int AW        = 16 + CAL_SHIFT;

    typedef enum logic {ST_CAL, ST_RUN} state_t;

    state_t                 r_state;
    logic [CAL_SHIFT-1:0]   r_cal_cnt;
    logic signed [AW-1:0]   r_rt_acc;
    logic signed [AW-1:0]   r_az_acc;
    logic [15:0]            r_rt_off;
    logic [15:0]            r_az_off;
    logic signed [26:0]     r_ptch_int;
    logic [15:0]            r_ptch;
    logic [15:0]            r_ptch_rt;
    logic                   r_vld;
    logic                   r_cal_done;

    logic signed [AW-1:0]   w_rt_sum;
    logic signed [AW-1:0]   w_az_sum;
    logic [16:0]            w_rt_diff;
    logic [16:0]            w_az_diff;
    logic [15:0]            w_rt_comp;
    logic [15:0]            w_az_comp;
    logic signed [25:0]     w_az_ext;
    logic signed [25:0]     w_prod;
    logic signed [25:0]     w_ptch_acc;
    logic signed [25:0]     w_ptch_ext;
    logic signed [26:0]     w_fusion;
    logic signed [26:0]     w_rt_ext;
    logic signed [26:0]     w_ptch_int_nxt;

    function automatic logic [15:0] sat17(input logic [16:0] d);
        if (d[16] != d[15])
            return d[16] ? 16'h8000 : 16'h7FFF;
        return d[15:0];
    endfunction

    always_comb begin
        w_rt_sum       = r_rt_acc + {{CAL_SHIFT{ptch_rt_raw[15]}}, ptch_rt_raw};
        w_az_sum       = r_az_acc + {{CAL_SHIFT{AZ[15]}}, AZ};
        w_rt_diff      = {ptch_rt_raw[15], ptch_rt_raw} - {r_rt_off[15], r_rt_off};
        w_az_diff      = {AZ[15], AZ} - {r_az_off[15], r_az_off};
        w_rt_comp      = sat17(w_rt_diff);
        w_az_comp      = sat17(w_az_diff);
        w_az_ext       = {{10{w_az_comp[15]}}, w_az_comp};
        w_prod         = w_az_ext * 26'sd327;
        // Arithmetic shift keeps the same value as sign-extending prod[25:13].
        w_ptch_acc     = w_prod >>> 13;
        w_ptch_ext     = {{10{r_ptch[15]}}, r_ptch};
        w_fusion       = (w_ptch_acc > w_ptch_ext) ? 27'(FUSION_GAIN) : -27'(FUSION_GAIN);
        w_rt_ext       = {{11{w_rt_comp[15]}}, w_rt_comp};
        w_ptch_int_nxt = r_ptch_int - w_rt_ext + w_fusion;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_CAL;
            r_cal_cnt  <= '0;
            r_rt_acc   <= '0;
            r_az_acc   <= '0;
            r_rt_off   <= '0;
            r_az_off   <= '0;
            r_ptch_int <= '0;
            r_ptch     <= '0;
            r_ptch_rt  <= '0;
            r_vld      <= 1'b0;
            r_cal_done <= 1'b0;
        end else if (clr) begin
            r_state    <= ST_CAL;
            r_cal_cnt  <= '0;
            r_rt_acc   <= '0;
            r_az_acc   <= '0;
            r_rt_off   <= '0;
            r_az_off   <= '0;
            r_ptch_int <= '0;
            r_ptch     <= '0;
            r_ptch_rt  <= '0;
            r_vld      <= 1'b0;
            r_cal_done <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            case (r_state)
                ST_CAL: begin
                    if (vld_in) begin
                        r_rt_acc  <= w_rt_sum;
                        r_az_acc  <= w_az_sum;
                        r_cal_cnt <= r_cal_cnt + CAL_SHIFT'(1);
                        // Top 16 bits of the full sum are the floor average.
                        if (&r_cal_cnt) begin
                            r_rt_off   <= w_rt_sum[CAL_SHIFT +: 16];
                            r_az_off   <= w_az_sum[CAL_SHIFT +: 16];
                            r_state    <= ST_RUN;
                            r_cal_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (vld_in) begin
                        r_ptch_int <= w_ptch_int_nxt;
                        r_ptch     <= w_ptch_int_nxt[26:11];
                        r_ptch_rt  <= w_rt_comp;
                        r_vld      <= 1'b1;
                    end
                end
                default: r_state <= ST_CAL;
            endcase
        end
    end

    assign ptch     = r_ptch;
    assign ptch_rt  = r_ptch_rt;
    assign vld      = r_vld;
    assign cal_done = r_cal_done;

endmodule
